bitop_rr_arbiter: RTL and testbench

Shares one registered bitwise logic unit (NAND/AND/OR/XOR) between two requesters with round-robin fairness. Each requester presents two operands and an opcode on a valid/ready channel. Results return on a single valid/ready result channel tagged with the requester ID. It sits between pin-decode logic and the output mux in the tt_um top level, and replaces direct pin-to-gate wiring.

---
 rtl/bitop_pkg.sv | 30 +++
 rtl/bitop_rr_arbiter_rr_arb2.sv | 34 +++
 rtl/bitop_rr_arbiter.sv | 85 ++++++++
 tb/tb_bitop_rr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitop_pkg.sv
// Shared types and the bitwise ALU used by the round-robin bit-operation unit.
package bitop_pkg;

    typedef enum logic [1:0] {
        OP_NAND = 2'b00,
        OP_AND  = 2'b01,
        OP_OR   = 2'b10,
        OP_XOR  = 2'b11
    } op_e;

    localparam int BITOP_WIDTH = 8;
    // Operands are widened to this size so one function serves any WIDTH up to 64.
    localparam int BITOP_MAX_W = 64;

    function automatic logic [BITOP_MAX_W-1:0] bitop_apply(
        input op_e                    op,
        input logic [BITOP_MAX_W-1:0] a,
        input logic [BITOP_MAX_W-1:0] b
    );
        logic [BITOP_MAX_W-1:0] r;
        case (op)
            OP_NAND: r = ~(a & b);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitop_rr_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the requester not granted last wins a contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       update
);

    logic r_last_grant;

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1)
            grant = r_last_grant ? 2'b01 : 2'b10;
        else if (valid0)
            grant = 2'b01;
        else if (valid1)
            grant = 2'b10;
    end

    assign update = enable & (grant[0] | grant[1]);

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_grant <= 1'b1;
        else if (update)
            r_last_grant <= grant[1];
    end

endmodule

// File: rtl/bitop_rr_arbiter.sv
// Registered NAND/AND/OR/XOR unit shared by two valid/ready requesters, round-robin arbitrated.
module bitop_rr_arbiter
    import bitop_pkg::*;
#(
    parameter int WIDTH = BITOP_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic [CNT_W-1:0] op_count
);

    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_id;
    logic [CNT_W-1:0] r_op_count;

    logic             w_can_accept;
    logic [1:0]       w_grant;
    logic             w_update;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [1:0]       w_op;

    // A result leaving this cycle frees the register for a new load on the same edge.
    assign w_can_accept = ~r_res_valid | res_ready;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .enable (w_can_accept),
        .grant  (w_grant),
        .update (w_update)
    );

    assign req0_ready = rst_n & w_can_accept & w_grant[0];
    assign req1_ready = rst_n & w_can_accept & w_grant[1];

    assign w_a  = w_grant[1] ? req1_a  : req0_a;
    assign w_b  = w_grant[1] ? req1_b  : req0_b;
    assign w_op = w_grant[1] ? req1_op : req0_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_update) begin
                r_res_data  <= WIDTH'(bitop_apply(op_e'(w_op),
                                                  BITOP_MAX_W'(w_a),
                                                  BITOP_MAX_W'(w_b)));
                r_res_id    <= w_grant[1];
                r_res_valid <= 1'b1;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
            if (r_res_valid && res_ready)
                r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_bitop_rr_arbiter.sv
// Scoreboard bench for bitop_rr_arbiter: driver predicts grants and results, monitor checks handshakes.
module tb_bitop_rr_arbiter;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]    req0_op = '0, req1_op = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;
    logic          res_id;
    logic [CW-1:0] op_count;

    bitop_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0] sb[$];

    // Pending operation per requester (held until accepted).
    logic         p_v[2];
    logic [W-1:0] p_a[2];
    logic [W-1:0] p_b[2];
    logic [1:0]   p_op[2];

    // Reference model state.
    logic         mdl_rv   = 1'b0;
    logic [W-1:0] mdl_data = '0;
    logic         mdl_id   = 1'b0;
    int           mdl_last = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0:    return ~(a & b);
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic load(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        p_v[n] = 1'b1; p_a[n] = a; p_b[n] = b; p_op[n] = op;
    endtask

    task automatic load_rand(input int n);
        load(n, W'($urandom), W'($urandom), 2'($urandom));
    endtask

    task automatic drive_cycle(input logic rr);
        logic can;
        int   win;
        logic [W-1:0] e;
        @(negedge clk);
        chk("res_valid", 32'(res_valid), 32'(mdl_rv));
        chk("res_data", 32'(res_data), 32'(mdl_data));
        chk("res_id", 32'(res_id), 32'(mdl_id));
        req0_valid = p_v[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_op = p_op[0];
        req1_valid = p_v[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_op = p_op[1];
        res_ready  = rr;
        #1;
        can = !mdl_rv || rr;
        if (p_v[0] && p_v[1]) win = (mdl_last == 0) ? 1 : 0;
        else if (p_v[0])      win = 0;
        else if (p_v[1])      win = 1;
        else                  win = -1;
        if (!can) win = -1;
        chk("req0_ready", 32'(req0_ready), 32'(win == 0));
        chk("req1_ready", 32'(req1_ready), 32'(win == 1));
        if (win >= 0) begin
            e = ref_alu(p_op[win], p_a[win], p_b[win]);
            sb.push_back({win[0], e});
            mdl_data = e;
            mdl_id   = win[0];
            mdl_rv   = 1'b1;
            mdl_last = win;
            p_v[win] = 1'b0;
        end else if (rr) begin
            mdl_rv = 1'b0;
        end
    endtask

    // Monitor: pops the expected result on each result handshake and tracks completions.
    initial begin : monitor
        logic [W:0] exp;
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                chk("op_count", 32'(op_count), 32'(cnt));
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_empty_on_result", 32'(1), 32'(0));
                    end else begin
                        exp = sb.pop_front();
                        chk("result_data", 32'(res_data), 32'(exp[W-1:0]));
                        chk("result_id", 32'(res_id), 32'(exp[W]));
                    end
                    cnt = (cnt + 1) % (1 << CW);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        p_a[0] = '0; p_a[1] = '0; p_b[0] = '0; p_b[1] = '0; p_op[0] = '0; p_op[1] = '0;

        // Reset state, with both requesters asking.
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_res_data", 32'(res_data), 32'(0));
        chk("rst_res_id", 32'(res_id), 32'(0));
        chk("rst_op_count", 32'(op_count), 32'(0));
        chk("rst_req0_ready", 32'(req0_ready), 32'(0));
        chk("rst_req1_ready", 32'(req1_ready), 32'(0));
        req0_valid = 1'b0; req1_valid = 1'b0;
        #3 rst_n = 1'b1;

        // Single NAND on requester 0.
        load(0, 8'hF0, 8'h3C, 2'b00);
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        chk("single_nand", 32'(res_data), 32'hCF);

        // All opcodes back to back on requester 1.
        for (int k = 0; k < 4; k++) begin
            load(1, 8'hA5, 8'h0F, 2'(k));
            drive_cycle(1'b1);
        end
        drive_cycle(1'b1);

        // Contention: both valid continuously, alternation expected.
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 2; n++) if (!p_v[n]) load_rand(n);
            drive_cycle(1'b1);
        end
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        drive_cycle(1'b1);

        // Back-pressure: hold a result for five cycles with both requesters waiting.
        load(0, 8'h12, 8'h34, 2'b11);
        drive_cycle(1'b0);
        load_rand(0); load_rand(1);
        repeat (5) drive_cycle(1'b0);
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        drive_cycle(1'b1);

        // Random traffic; CNT_W=4 makes op_count wrap many times.
        for (int k = 0; k < 400; k++) begin
            for (int n = 0; n < 2; n++)
                if (!p_v[n] && ($urandom_range(0, 99) < 60)) load_rand(n);
            drive_cycle(1'($urandom_range(0, 99) < 70));
        end

        // Reset while a result is held.
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        drive_cycle(1'b1);
        load_rand(0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        chk("pre_reset_valid", 32'(res_valid), 32'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", 32'(res_valid), 32'(0));
        chk("midrst_op_count", 32'(op_count), 32'(0));
        sb.delete();
        mdl_rv = 1'b0; mdl_data = '0; mdl_id = 1'b0; mdl_last = 1;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        @(negedge clk);
        #4 rst_n = 1'b1;

        // After reset requester 0 must win the first contention.
        load_rand(0); load_rand(1);
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        repeat (3) drive_cycle(1'b1);

        @(negedge clk);
        #4;
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
